fa_request_fifo: RTL
====================

// Module: fa_request_fifo
// PURPOSE
//  Fully associative request queue on the conf_regs simple interface (si_*); next generation of the single request register.
//  Captures every si write addressed to MY_ADDR into a DEPTH-entry FIFO instead of overwriting one value.
//  Back-pressures the bus when full. The consumer reads the head and pops it with data_ack.
//  Sits between the host-side address/data decoder and a request-consuming engine (e.g. trigger/acquisition control).
// PARAMETERS
//  ADDR_WIDTH      16        si_addr width
//  DATA_WIDTH      16        si_data / data width
//  MY_ADDR         16'h000a  address this queue answers to (compared over ADDR_WIDTH bits)
//  MY_RESET_VALUE  16'h0000  value driven on data while the queue is empty
//  DEPTH           4         entries; power of two, >= 2
//  localparam PTR_W = $clog2(DEPTH)
// PORTS
//  clk         in   1             system clock, all state on rising edge
//  rst         in   1             asynchronous, active-low reset (0 = reset)
//  si_addr     in   ADDR_WIDTH    request address
//  si_data     in   DATA_WIDTH    request data
//  si_rdy      in   1             si transfer valid
//  si_ack      out  1             combinational accept: si_rdy & (si_addr==MY_ADDR) & !full & !flush
//  flush       in   1             synchronous clear of all entries
//  data_ack    in   1             consumer pops head (ignored when empty)
//  data        out  DATA_WIDTH    head entry; MY_RESET_VALUE when empty
//  data_valid  out  1             queue non-empty
//  full        out  1             count == DEPTH
// BEHAVIOUR
//  - Reset (rst=0, async): rd_ptr=wr_ptr=0, count=0. Outputs: data_valid=0, full=0, data=MY_RESET_VALUE, si_ack follows its equation.
//    Entry storage is not reset. Reset mid-transfer discards everything; on release the queue behaves as fresh.
//  - push = si_ack. pop = data_ack & data_valid & !flush.
//  - On push: mem[wr_ptr] <= si_data; wr_ptr++ (wraps mod DEPTH).
//  - On pop: rd_ptr++ (wraps mod DEPTH).
//  - count: +1 on push only, -1 on pop only, unchanged on push & pop.
//  - Push and pop in the same cycle is legal whenever not full. No combinational path from data_ack to si_ack, so a full
//    queue refuses the write even if data_ack is high in that cycle.
//  - Latency: a write accepted at edge N is visible on data/data_valid after edge N when the queue was empty. There is no
//    same-cycle bypass.
//  - data = data_valid ? mem[rd_ptr] : MY_RESET_VALUE, muxed from registers (glitch-free, no RAM read latency).
//  - flush: at the next edge ptrs=0 and count=0. si_ack is forced 0 during flush, so there is no push. data_ack is ignored.
//  - data_ack while empty: no effect, no underflow. Writes to other addresses: si_ack=0, no state change.
//  - full = (count==DEPTH). data_valid = (count!=0). count is PTR_W+1 bits wide.
//  - Order is strictly FIFO. No coalescing of repeated writes.
// CONFIGURATION
//  FA_REQUEST_FIFO_LEVEL_EN defined:
//    extra output port  level  out  PTR_W+1  current count (0..DEPTH), registered, reset 0.
//  FA_REQUEST_FIFO_LEVEL_EN undefined:
//    port absent; count stays internal. All other behaviour is identical.
// STRUCTURE
//  - Shared package conf_regs_pkg holds the register address map constants (MY_ADDR values per request queue) and the default
//    DATA/ADDR widths used by all conf_regs blocks.
//  - One sub-module, request_fifo_core: pointers, count, storage array, full/valid flags.
//    Parameters: DATA_WIDTH, DEPTH. Ports: push, pop, flush, din, dout, count.
//  - The top owns the address compare, si_ack, the MY_RESET_VALUE output mux and the optional level port.
// TESTING (DEPTH=4, MY_ADDR=16'h000a, MY_RESET_VALUE=0)
//  1. Reset, then single write si_addr=0x000a, si_data=0x1234, 1 cycle
//     -> si_ack=1 that cycle; next cycle data=0x1234, data_valid=1; data_ack 1 cycle -> data=0, data_valid=0.
//  2. Write 0x0001..0x0005 back-to-back with si_rdy held
//     -> si_ack=1 for the first 4, full=1, si_ack=0 on 0x0005 until a pop; pops return 1,2,3,4, then 5 after re-accept.
//  3. Queue holds 2 entries; push 0xBEEF with data_ack in the same cycle
//     -> count stays 2, old head popped, 0xBEEF is last; repeat 8 times to exercise pointer wrap with no loss.
//  4. Write to si_addr=0x000b -> si_ack=0, data_valid unchanged.
//     data_ack on empty queue -> no change, data=0.
//  5. Queue holds 3 entries; flush=1 with si_rdy=1 to MY_ADDR and data_ack=1
//     -> si_ack=0, next cycle data_valid=0, full=0, data=0.
//  6. Queue holds 3 entries; assert rst=0 mid-cycle, asynchronously
//     -> data_valid=0, data=0 immediately without a clock edge; after release a write to 0x000a is accepted normally.
//     With FA_REQUEST_FIFO_LEVEL_EN, level tracks 0..4 across tests 2, 3 and 5.

Source files
------------

// File: rtl/conf_regs_pkg.sv
// rtl/conf_regs_pkg.sv - shared conf_regs address map and default bus widths
package conf_regs_pkg;

    localparam int CONF_ADDR_WIDTH = 16;
    localparam int CONF_DATA_WIDTH = 16;

    typedef logic [CONF_ADDR_WIDTH-1:0] conf_addr_t;
    typedef logic [CONF_DATA_WIDTH-1:0] conf_data_t;

    // One address per request queue hanging off the si bus
    localparam conf_addr_t REQ_QUEUE_ADDR = 16'h000a;
    localparam conf_addr_t TRIG_QUEUE_ADDR = 16'h000c;

    localparam conf_data_t REQ_QUEUE_RESET_VALUE = 16'h0000;

endpackage

// File: rtl/request_fifo_core.sv
// rtl/request_fifo_core.sv - register-based FIFO storage with pointers, count and flags
module request_fifo_core #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      din,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       valid
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign valid = (count != '0);

endmodule

// File: rtl/fa_request_fifo.sv
// rtl/fa_request_fifo.sv - si-bus request queue; FA_REQUEST_FIFO_LEVEL_EN adds the level port
module fa_request_fifo
    import conf_regs_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = CONF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = CONF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] MY_ADDR        = ADDR_WIDTH'(REQ_QUEUE_ADDR),
    parameter logic [DATA_WIDTH-1:0] MY_RESET_VALUE = DATA_WIDTH'(REQ_QUEUE_RESET_VALUE),
    parameter int                    DEPTH          = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   si_addr,
    input  logic [DATA_WIDTH-1:0]   si_data,
    input  logic                    si_rdy,
    output logic                    si_ack,
    input  logic                    flush,
    input  logic                    data_ack,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    data_valid,
    output logic                    full
`ifdef FA_REQUEST_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]  level
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
    logic [PTR_W:0]        count;

    // si_ack depends only on registered flags, never on data_ack
    assign si_ack = si_rdy & (si_addr == MY_ADDR) & ~full & ~flush;
    assign push   = si_ack;
    assign pop    = data_ack & data_valid & ~flush;

    request_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (si_data),
        .dout  (head),
        .count (count),
        .full  (full),
        .valid (data_valid)
    );

    assign data = data_valid ? head : MY_RESET_VALUE;

`ifdef FA_REQUEST_FIFO_LEVEL_EN
    assign level = count;
`else
    logic unused_count;
    assign unused_count = ^count;
`endif

endmodule
